gpu_bus_mem_scheduler: RTL and testbench

Bus-mode scheduler between the GPU pixel-pipeline requesters (BG read, CLUT$ L/R, TEX$ L/R, BG write) and the single DDR command/data port. It grants one requester at a time by fixed priority, with anti-starvation for BG write. It converts the grant into one DDR burst command, counts returned beats and routes them to the requester with completion strobes. Sits inside the GPU memory subsystem, upstream of the DDR controller; inactive while FIFO mode owns memory.

---
 rtl/gpu_bus_mem_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_gpu_bus_mem_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_bus_mem_scheduler.sv
// gpu_bus_mem_scheduler
//   Bus-mode scheduler between the GPU pixel-pipeline requesters and the single
//   DDR command/data port. One requester is granted at a time by fixed priority
//   (BG read > CLUT L > CLUT R > TEX L > TEX R > BG write). BG write is promoted
//   to the top once it has watched WR_STARVE_MAX other grants go by. The grant
//   becomes one DDR burst command; returned beats are counted and routed to the
//   granted requester together with its completion strobe.
//
// Ports
//   gpuClk, i_nRst              clock, synchronous active-low reset
//   i_fifoModeActive            FIFO mode owns DDR: no new grants
//   requTexCacheUpdateL/R, adrTexCacheUpdateL/R (17b)    TEX$ miss requests
//   updateTexCacheCompleteL/R, adrTexCacheWrite, TexCacheWrite, TexCacheData
//   requClutCacheUpdateL/R, adrClutCacheUpdateL/R (15b)  CLUT$ miss requests
//   updateClutCacheCompleteL/R, ClutCacheWrite, ClutWriteIndex, ClutCacheData
//   bgRequest, bgRequestAdr     BG read request; validbgPixel, bgPixel
//   bgWriteRequest, write32, bgWriteAdr, pixelValid      BG write; writePixelDone
//   o_memCmd*, i_memCmdReady    DDR command channel
//   o_memWriteData/Mask         DDR write data and byte enables
//   i_memReadValid/Data         DDR read beats
//   o_busy                      scheduler not idle
module gpu_bus_mem_scheduler #(
    parameter int WR_STARVE_MAX = 15
) (
    input  logic        gpuClk,
    input  logic        i_nRst,
    input  logic        i_fifoModeActive,
    input  logic        requTexCacheUpdateL,
    input  logic        requTexCacheUpdateR,
    input  logic [16:0] adrTexCacheUpdateL,
    input  logic [16:0] adrTexCacheUpdateR,
    output logic        updateTexCacheCompleteL,
    output logic        updateTexCacheCompleteR,
    output logic [16:0] adrTexCacheWrite,
    output logic        TexCacheWrite,
    output logic [63:0] TexCacheData,
    input  logic        requClutCacheUpdateL,
    input  logic        requClutCacheUpdateR,
    input  logic [14:0] adrClutCacheUpdateL,
    input  logic [14:0] adrClutCacheUpdateR,
    output logic        updateClutCacheCompleteL,
    output logic        updateClutCacheCompleteR,
    output logic        ClutCacheWrite,
    output logic [6:0]  ClutWriteIndex,
    output logic [31:0] ClutCacheData,
    input  logic        bgRequest,
    input  logic [17:0] bgRequestAdr,
    output logic        validbgPixel,
    output logic [31:0] bgPixel,
    input  logic        bgWriteRequest,
    input  logic [31:0] write32,
    input  logic [17:0] bgWriteAdr,
    input  logic [1:0]  pixelValid,
    output logic        writePixelDone,
    output logic        o_memCmdValid,
    input  logic        i_memCmdReady,
    output logic        o_memCmdWrite,
    output logic [17:0] o_memCmdAdr,
    output logic [3:0]  o_memCmdBeats,
    output logic [31:0] o_memWriteData,
    output logic [3:0]  o_memWriteMask,
    input  logic        i_memReadValid,
    input  logic [31:0] i_memReadData,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    typedef enum logic [2:0] {
        REQ_BGRD, REQ_CLUTL, REQ_CLUTR, REQ_TEXL, REQ_TEXR, REQ_BGWR
    } requester_t;

    localparam logic [7:0] STARVE_LIMIT = 8'(WR_STARVE_MAX);

    state_t     state, stateNext;
    requester_t grant, winner;

    // Command latched at grant time; requester inputs are not looked at again.
    logic [17:0] cmdAdr;
    logic [3:0]  cmdBeats;
    logic        cmdWrite;
    logic [31:0] wrData;
    logic [3:0]  wrMask;
    logic [3:0]  beatCnt;
    logic [31:0] texBeat0;
    logic [7:0]  starveCnt;

    logic        anyRequest, grantNow;
    logic [17:0] winAdr;
    logic [3:0]  winBeats;
    logic        winWrite;
    logic [3:0]  winMask;

    assign anyRequest = bgRequest | requClutCacheUpdateL | requClutCacheUpdateR |
                        requTexCacheUpdateL | requTexCacheUpdateR | bgWriteRequest;
    assign grantNow   = (state == IDLE) && !i_fifoModeActive && anyRequest;

    // Arbitration and command mapping of the would-be winner.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        winner   = REQ_BGWR;
        winAdr   = bgWriteAdr;
        winBeats = 4'd1;
        winWrite = 1'b0;
        winMask  = 4'b0000;
        if (bgWriteRequest && starveCnt >= STARVE_LIMIT) winner = REQ_BGWR;
        else if (bgRequest)                              winner = REQ_BGRD;
        else if (requClutCacheUpdateL)                   winner = REQ_CLUTL;
        else if (requClutCacheUpdateR)                   winner = REQ_CLUTR;
        else if (requTexCacheUpdateL)                    winner = REQ_TEXL;
        else if (requTexCacheUpdateR)                    winner = REQ_TEXR;
        case (winner)
            REQ_BGRD:  winAdr = bgRequestAdr;
            REQ_CLUTL: begin winAdr = {adrClutCacheUpdateL, 3'b000}; winBeats = 4'd8; end
            REQ_CLUTR: begin winAdr = {adrClutCacheUpdateR, 3'b000}; winBeats = 4'd8; end
            REQ_TEXL:  begin winAdr = {adrTexCacheUpdateL, 1'b0};    winBeats = 4'd2; end
            REQ_TEXR:  begin winAdr = {adrTexCacheUpdateR, 1'b0};    winBeats = 4'd2; end
            default: begin
                winWrite = 1'b1;
                winMask  = {pixelValid[1], pixelValid[1], pixelValid[0], pixelValid[0]};
            end
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            // A write with no enabled pixel never touches DDR.
            IDLE: if (grantNow) stateNext = (winWrite && winMask == 4'b0000) ? DONE : CMD;
            CMD:  if (i_memCmdReady) stateNext = cmdWrite ? DONE : DATA;
            DATA: if (i_memReadValid && beatCnt == cmdBeats - 4'd1) stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other one.
    always_ff @(posedge gpuClk) begin
        if (!i_nRst) begin
            // NOTE: datapath registers are reset as well, so nothing captured
            // before reset can reach an output afterwards.
            state     <= IDLE;
            grant     <= REQ_BGRD;
            cmdAdr    <= '0;
            cmdBeats  <= '0;
            cmdWrite  <= 1'b0;
            wrData    <= '0;
            wrMask    <= '0;
            beatCnt   <= '0;
            texBeat0  <= '0;
            starveCnt <= '0;
        end else begin
            state <= stateNext;
            if (grantNow) begin
                grant    <= winner;
                cmdAdr   <= winAdr;
                cmdBeats <= winBeats;
                cmdWrite <= winWrite;
                wrData   <= winWrite ? write32 : 32'd0;
                wrMask   <= winMask;
                beatCnt  <= '0;
            end
            if (state == DATA && i_memReadValid) begin
                beatCnt <= beatCnt + 4'd1;
                if (beatCnt == 4'd0) texBeat0 <= i_memReadData;
            end
            if (!bgWriteRequest)
                starveCnt <= '0;
            else if (grantNow) begin
                if (winner == REQ_BGWR)    starveCnt <= '0;
                else if (starveCnt != 8'hFF) starveCnt <= starveCnt + 8'd1;
            end
        end
    end

    logic inCmd, beatHere, grantClut, grantTex, clutBeat, texWrite;

    assign inCmd     = (state == CMD);
    assign beatHere  = (state == DATA) && i_memReadValid;
    assign grantClut = (grant == REQ_CLUTL) || (grant == REQ_CLUTR);
    assign grantTex  = (grant == REQ_TEXL)  || (grant == REQ_TEXR);
    assign clutBeat  = beatHere && grantClut;
    assign texWrite  = beatHere && grantTex && (beatCnt == 4'd1);

    assign o_busy         = (state != IDLE);
    assign o_memCmdValid  = inCmd;
    assign o_memCmdWrite  = inCmd && cmdWrite;
    assign o_memCmdAdr    = inCmd ? cmdAdr   : 18'd0;
    assign o_memCmdBeats  = inCmd ? cmdBeats : 4'd0;
    assign o_memWriteData = (inCmd && cmdWrite) ? wrData : 32'd0;
    assign o_memWriteMask = (inCmd && cmdWrite) ? wrMask : 4'd0;

    assign validbgPixel = beatHere && (grant == REQ_BGRD);
    assign bgPixel      = validbgPixel ? i_memReadData : 32'd0;

    // CLUT block address bits [3:0] sit at cmdAdr[6:3] after the 3-bit beat shift.
    assign ClutCacheWrite           = clutBeat;
    assign ClutWriteIndex           = clutBeat ? {cmdAdr[6:3], beatCnt[2:0]} : 7'd0;
    assign ClutCacheData            = clutBeat ? i_memReadData : 32'd0;
    assign updateClutCacheCompleteL = clutBeat && (grant == REQ_CLUTL) && (beatCnt == 4'd7);
    assign updateClutCacheCompleteR = clutBeat && (grant == REQ_CLUTR) && (beatCnt == 4'd7);

    // The chunk address is cmdAdr without the appended zero bit.
    assign TexCacheWrite           = texWrite;
    assign TexCacheData            = texWrite ? {i_memReadData, texBeat0} : 64'd0;
    assign adrTexCacheWrite        = texWrite ? cmdAdr[17:1] : 17'd0;
    assign updateTexCacheCompleteL = texWrite && (grant == REQ_TEXL);
    assign updateTexCacheCompleteR = texWrite && (grant == REQ_TEXR);

    assign writePixelDone = (state == DONE) && cmdWrite;

endmodule

// File: tb/tb_gpu_bus_mem_scheduler.sv
// Self-checking bench for gpu_bus_mem_scheduler: expected DDR commands and
// requester-side events are queued when a request is raised, and popped as the
// DUT produces them. A small DDR model returns read beats one cycle after each
// accepted read command, with data taken from a queue filled by the stimulus.
module tb_gpu_bus_mem_scheduler;

    logic        gpuClk, i_nRst, i_fifoModeActive;
    logic        requTexCacheUpdateL, requTexCacheUpdateR;
    logic [16:0] adrTexCacheUpdateL, adrTexCacheUpdateR;
    logic        updateTexCacheCompleteL, updateTexCacheCompleteR;
    logic [16:0] adrTexCacheWrite;
    logic        TexCacheWrite;
    logic [63:0] TexCacheData;
    logic        requClutCacheUpdateL, requClutCacheUpdateR;
    logic [14:0] adrClutCacheUpdateL, adrClutCacheUpdateR;
    logic        updateClutCacheCompleteL, updateClutCacheCompleteR;
    logic        ClutCacheWrite;
    logic [6:0]  ClutWriteIndex;
    logic [31:0] ClutCacheData;
    logic        bgRequest;
    logic [17:0] bgRequestAdr;
    logic        validbgPixel;
    logic [31:0] bgPixel;
    logic        bgWriteRequest;
    logic [31:0] write32;
    logic [17:0] bgWriteAdr;
    logic [1:0]  pixelValid;
    logic        writePixelDone;
    logic        o_memCmdValid, i_memCmdReady, o_memCmdWrite;
    logic [17:0] o_memCmdAdr;
    logic [3:0]  o_memCmdBeats;
    logic [31:0] o_memWriteData;
    logic [3:0]  o_memWriteMask;
    logic        i_memReadValid;
    logic [31:0] i_memReadData;
    logic        o_busy;

    gpu_bus_mem_scheduler #(.WR_STARVE_MAX(15)) dut (
        .gpuClk(gpuClk), .i_nRst(i_nRst), .i_fifoModeActive(i_fifoModeActive),
        .requTexCacheUpdateL(requTexCacheUpdateL), .requTexCacheUpdateR(requTexCacheUpdateR),
        .adrTexCacheUpdateL(adrTexCacheUpdateL), .adrTexCacheUpdateR(adrTexCacheUpdateR),
        .updateTexCacheCompleteL(updateTexCacheCompleteL),
        .updateTexCacheCompleteR(updateTexCacheCompleteR),
        .adrTexCacheWrite(adrTexCacheWrite), .TexCacheWrite(TexCacheWrite),
        .TexCacheData(TexCacheData),
        .requClutCacheUpdateL(requClutCacheUpdateL), .requClutCacheUpdateR(requClutCacheUpdateR),
        .adrClutCacheUpdateL(adrClutCacheUpdateL), .adrClutCacheUpdateR(adrClutCacheUpdateR),
        .updateClutCacheCompleteL(updateClutCacheCompleteL),
        .updateClutCacheCompleteR(updateClutCacheCompleteR),
        .ClutCacheWrite(ClutCacheWrite), .ClutWriteIndex(ClutWriteIndex),
        .ClutCacheData(ClutCacheData),
        .bgRequest(bgRequest), .bgRequestAdr(bgRequestAdr),
        .validbgPixel(validbgPixel), .bgPixel(bgPixel),
        .bgWriteRequest(bgWriteRequest), .write32(write32), .bgWriteAdr(bgWriteAdr),
        .pixelValid(pixelValid), .writePixelDone(writePixelDone),
        .o_memCmdValid(o_memCmdValid), .i_memCmdReady(i_memCmdReady),
        .o_memCmdWrite(o_memCmdWrite), .o_memCmdAdr(o_memCmdAdr),
        .o_memCmdBeats(o_memCmdBeats), .o_memWriteData(o_memWriteData),
        .o_memWriteMask(o_memWriteMask),
        .i_memReadValid(i_memReadValid), .i_memReadData(i_memReadData),
        .o_busy(o_busy)
    );

    typedef struct {
        logic [17:0] adr;
        logic [3:0]  beats;
        logic        write;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } cmd_t;

    // strobes = {validbgPixel, ClutCacheWrite, TexCacheWrite, writePixelDone}
    // cmpl    = {texL, texR, clutL, clutR}
    typedef struct {
        logic [3:0]  strobes;
        logic [63:0] data;
        logic [16:0] aux;
        logic [3:0]  cmpl;
    } ev_t;

    cmd_t        cmdQ[$];
    ev_t         evQ[$];
    logic [31:0] rdDataQ[$];

    int checks = 0;
    int failures = 0;
    int cmdValidCycles = 0;
    int clutBeatsSeen = 0;
    bit holdBgRead = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        gpuClk = 1'b0;
        forever #5 gpuClk = ~gpuClk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DDR model: read beats start the cycle after command acceptance, one per cycle.
    initial begin
        int pend;
        logic acc;
        logic [3:0] accBeats;
        pend = 0;
        i_memReadValid = 1'b0;
        i_memReadData  = 32'd0;
        forever begin
            @(negedge gpuClk);
            acc      = o_memCmdValid && i_memCmdReady && !o_memCmdWrite;
            accBeats = o_memCmdBeats;
            @(posedge gpuClk);
            #1;
            if (!i_nRst)  pend = 0;
            else if (acc) pend += int'(accBeats);
            if (pend > 0) begin
                i_memReadValid = 1'b1;
                i_memReadData  = (rdDataQ.size() != 0) ? rdDataQ.pop_front() : 32'hDEAD_BEEF;
                pend--;
            end else begin
                i_memReadValid = 1'b0;
                i_memReadData  = 32'd0;
            end
        end
    end

    // Monitor: commands and requester events against the scoreboard queues.
    always @(negedge gpuClk) begin
        cmd_t c;
        ev_t  e;
        logic [3:0] strobes, cmpl;
        strobes = {validbgPixel, ClutCacheWrite, TexCacheWrite, writePixelDone};
        cmpl    = {updateTexCacheCompleteL, updateTexCacheCompleteR,
                   updateClutCacheCompleteL, updateClutCacheCompleteR};
        if (o_memCmdValid && i_memCmdReady) begin
            if (cmdQ.size() == 0) check("cmd_unexpected", o_memCmdAdr, 64'hFFFF_FFFF);
            else begin
                c = cmdQ.pop_front();
                check("cmd_adr",   o_memCmdAdr,    c.adr);
                check("cmd_beats", o_memCmdBeats,  c.beats);
                check("cmd_write", o_memCmdWrite,  c.write);
                check("cmd_mask",  o_memWriteMask, c.mask);
                check("cmd_wdata", o_memWriteData, c.wdata);
            end
        end
        if (strobes != 4'b0000) begin
            if (evQ.size() == 0) check("ev_unexpected", strobes, 4'b0000);
            else begin
                e = evQ.pop_front();
                check("ev_strobes", strobes, e.strobes);
                check("ev_data", TexCacheData | {32'd0, ClutCacheData} | {32'd0, bgPixel}, e.data);
                check("ev_aux", adrTexCacheWrite | {10'd0, ClutWriteIndex}, e.aux);
                check("ev_cmpl", cmpl, e.cmpl);
            end
        end else if (cmpl != 4'b0000) check("cmpl_stray", cmpl, 4'b0000);
        if (!o_memCmdValid && ({o_memCmdWrite, o_memCmdAdr, o_memCmdBeats, o_memWriteMask} != '0 ||
                               o_memWriteData != 32'd0))
            check("cmd_idle_zero", {o_memCmdAdr, o_memWriteData}, 64'd0);
        if (!validbgPixel && bgPixel != 32'd0) check("bg_idle_zero", bgPixel, 64'd0);
        if (!ClutCacheWrite && {ClutWriteIndex, ClutCacheData} != '0)
            check("clut_idle_zero", {ClutWriteIndex, ClutCacheData}, 64'd0);
        if (!TexCacheWrite && TexCacheData != 64'd0) check("tex_data_idle_zero", TexCacheData, 64'd0);
        if (!TexCacheWrite && adrTexCacheWrite != 17'd0) check("tex_adr_idle_zero", adrTexCacheWrite, 64'd0);
    end

    task automatic expBgRead(input logic [17:0] adr, input logic [31:0] d);
        ev_t e;
        cmdQ.push_back('{adr: adr, beats: 4'd1, write: 1'b0, mask: 4'd0, wdata: 32'd0});
        rdDataQ.push_back(d);
        e.strobes = 4'b1000; e.data = {32'd0, d}; e.aux = '0; e.cmpl = 4'b0000;
        evQ.push_back(e);
    endtask

    task automatic expClut(input bit side, input logic [14:0] adr, input logic [31:0] base);
        ev_t e;
        logic [31:0] d;
        cmdQ.push_back('{adr: {adr, 3'b000}, beats: 4'd8, write: 1'b0, mask: 4'd0, wdata: 32'd0});
        for (int b = 0; b < 8; b++) begin
            d = base + 32'(b);
            rdDataQ.push_back(d);
            e.strobes = 4'b0100;
            e.data    = {32'd0, d};
            e.aux     = {10'd0, adr[3:0], 3'(b)};
            e.cmpl    = (b == 7) ? (side ? 4'b0001 : 4'b0010) : 4'b0000;
            evQ.push_back(e);
        end
    endtask

    task automatic expTex(input bit side, input logic [16:0] adr, input logic [31:0] d0,
                          input logic [31:0] d1);
        ev_t e;
        cmdQ.push_back('{adr: {adr, 1'b0}, beats: 4'd2, write: 1'b0, mask: 4'd0, wdata: 32'd0});
        rdDataQ.push_back(d0);
        rdDataQ.push_back(d1);
        e.strobes = 4'b0010; e.data = {d1, d0}; e.aux = adr;
        e.cmpl = side ? 4'b0100 : 4'b1000;
        evQ.push_back(e);
    endtask

    task automatic expBgWrite(input logic [17:0] adr, input logic [31:0] d, input logic [1:0] pv);
        ev_t e;
        if (pv != 2'b00)
            cmdQ.push_back('{adr: adr, beats: 4'd1, write: 1'b1,
                             mask: {pv[1], pv[1], pv[0], pv[0]}, wdata: d});
        e.strobes = 4'b0001; e.data = '0; e.aux = '0; e.cmpl = 4'b0000;
        evQ.push_back(e);
    endtask

    // One cycle of requester behaviour: drop a level request on its completion pulse.
    task automatic cycleDrop();
        @(negedge gpuClk);
        if (o_memCmdValid) cmdValidCycles++;
        if (ClutCacheWrite) clutBeatsSeen++;
        if (validbgPixel && !holdBgRead) bgRequest = 1'b0;
        if (updateClutCacheCompleteL) requClutCacheUpdateL = 1'b0;
        if (updateClutCacheCompleteR) requClutCacheUpdateR = 1'b0;
        if (updateTexCacheCompleteL)  requTexCacheUpdateL  = 1'b0;
        if (updateTexCacheCompleteR)  requTexCacheUpdateR  = 1'b0;
        if (writePixelDone) begin
            bgWriteRequest = 1'b0;
            if (holdBgRead) bgRequest = 1'b0;
        end
    endtask

    function automatic bit anyReq();
        return bgRequest | bgWriteRequest | requClutCacheUpdateL | requClutCacheUpdateR |
               requTexCacheUpdateL | requTexCacheUpdateR;
    endfunction

    task automatic runIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        do begin
            cycleDrop();
            n++;
        end while (n < maxCycles &&
                   (o_busy || evQ.size() != 0 || cmdQ.size() != 0 || anyReq()));
        check({tag, "_done"}, {o_busy, evQ.size() != 0, cmdQ.size() != 0, anyReq()}, 4'b0000);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_cmd"}, {o_memCmdValid, o_memCmdWrite, o_memCmdAdr, o_memCmdBeats,
                              o_memWriteMask}, 64'd0);
        check({tag, "_wdata"}, o_memWriteData, 64'd0);
        check({tag, "_strobes"}, {updateTexCacheCompleteL, updateTexCacheCompleteR, TexCacheWrite,
                                  updateClutCacheCompleteL, updateClutCacheCompleteR, ClutCacheWrite,
                                  validbgPixel, writePixelDone, o_busy}, 64'd0);
        check({tag, "_texdata"}, TexCacheData, 64'd0);
        check({tag, "_adrs"}, {adrTexCacheWrite, ClutWriteIndex}, 64'd0);
        check({tag, "_data"}, {ClutCacheData, bgPixel}, 64'd0);
    endtask

    initial begin
        int n;
        int busyCycles;
        i_nRst = 1'b0; i_fifoModeActive = 1'b0; i_memCmdReady = 1'b1;
        requTexCacheUpdateL = 1'b0; requTexCacheUpdateR = 1'b0;
        adrTexCacheUpdateL = '0; adrTexCacheUpdateR = '0;
        requClutCacheUpdateL = 1'b0; requClutCacheUpdateR = 1'b0;
        adrClutCacheUpdateL = '0; adrClutCacheUpdateR = '0;
        bgRequest = 1'b0; bgRequestAdr = '0;
        bgWriteRequest = 1'b0; write32 = '0; bgWriteAdr = '0; pixelValid = 2'b00;

        // Reset with every request high, then full priority sweep.
        bgRequest = 1'b1;            bgRequestAdr = 18'h2AAAA;
        requClutCacheUpdateL = 1'b1; adrClutCacheUpdateL = 15'h1234;
        requClutCacheUpdateR = 1'b1; adrClutCacheUpdateR = 15'h7FFF;
        requTexCacheUpdateL = 1'b1;  adrTexCacheUpdateL = 17'h00ABC;
        requTexCacheUpdateR = 1'b1;  adrTexCacheUpdateR = 17'h1FFFF;
        bgWriteRequest = 1'b1; bgWriteAdr = 18'h15555; write32 = 32'h89AB_CDEF; pixelValid = 2'b01;
        repeat (3) @(posedge gpuClk);
        @(negedge gpuClk);
        checkAllZero("rst");
        expBgRead(18'h2AAAA, 32'hCAFE_F00D);
        expClut(1'b0, 15'h1234, 32'h1000_0000);
        expClut(1'b1, 15'h7FFF, 32'h2000_0000);
        expTex(1'b0, 17'h00ABC, 32'h0BAD_0001, 32'h0BAD_0002);
        expTex(1'b1, 17'h1FFFF, 32'hAAAA_5555, 32'h1234_5678);
        expBgWrite(18'h15555, 32'h89AB_CDEF, 2'b01);
        i_nRst = 1'b1;
        runIdle("order", 300);

        // BG write starved by a continuously re-requested BG read.
        holdBgRead = 1'b1;
        for (int i = 0; i < 15; i++) expBgRead(18'h01000, 32'h5000_0000 + 32'(i));
        expBgWrite(18'h00777, 32'h0BAD_F00D, 2'b10);
        bgRequestAdr = 18'h01000;
        bgWriteAdr = 18'h00777; write32 = 32'h0BAD_F00D; pixelValid = 2'b10;
        bgRequest = 1'b1; bgWriteRequest = 1'b1;
        runIdle("starve", 400);
        holdBgRead = 1'b0;

        // BG write with no enabled pixel: no DDR command, single done pulse.
        cmdValidCycles = 0;
        expBgWrite(18'h00100, 32'h1111_2222, 2'b00);
        bgWriteAdr = 18'h00100; write32 = 32'h1111_2222; pixelValid = 2'b00;
        bgWriteRequest = 1'b1;
        runIdle("nomask", 20);
        check("nomask_cmdvalid", cmdValidCycles, 64'd0);

        // Command stall: fields hold while ready is low; request changes ignored.
        @(posedge gpuClk); #1 i_memCmdReady = 1'b0;
        clutBeatsSeen = 0;
        expClut(1'b0, 15'h0055, 32'h7777_0000);
        adrClutCacheUpdateL = 15'h0055; requClutCacheUpdateL = 1'b1;
        n = 0;
        do begin cycleDrop(); n++; end while (!o_memCmdValid && n < 10);
        check("stall_start", o_memCmdValid, 64'd1);
        requClutCacheUpdateL = 1'b0; adrClutCacheUpdateL = 15'h7777;
        for (int i = 0; i < 5; i++) begin
            cycleDrop();
            check("stall_cmd", {o_memCmdValid, o_memCmdAdr, o_memCmdBeats},
                  {1'b1, 18'h002A8, 4'd8});
        end
        @(posedge gpuClk); #1 i_memCmdReady = 1'b1;

        // FIFO mode raised mid-burst: burst finishes, then no grant until it falls.
        n = 0;
        do begin cycleDrop(); n++; end while (clutBeatsSeen < 3 && n < 30);
        i_fifoModeActive = 1'b1;
        bgRequestAdr = 18'h00123; bgRequest = 1'b1;
        n = 0;
        do begin cycleDrop(); n++; end while (o_busy && n < 30);
        check("fifo_burst", {o_busy, 4'(clutBeatsSeen), evQ.size() != 0}, {1'b0, 4'd8, 1'b0});
        busyCycles = 0;
        for (int i = 0; i < 8; i++) begin
            cycleDrop();
            if (o_busy) busyCycles++;
        end
        check("fifo_hold", busyCycles, 64'd0);
        expBgRead(18'h00123, 32'hF1F0_0123);
        i_fifoModeActive = 1'b0;
        runIdle("fifo_release", 30);

        // Reset in the middle of a CLUT burst.
        clutBeatsSeen = 0;
        expClut(1'b1, 15'h0003, 32'h3300_0000);
        adrClutCacheUpdateR = 15'h0003; requClutCacheUpdateR = 1'b1;
        n = 0;
        do begin cycleDrop(); n++; end while (clutBeatsSeen < 2 && n < 30);
        check("midrst_beats", clutBeatsSeen, 64'd2);
        i_nRst = 1'b0;
        requClutCacheUpdateR = 1'b0;
        @(posedge gpuClk);
        #2;
        cmdQ.delete(); evQ.delete(); rdDataQ.delete();
        @(negedge gpuClk);
        checkAllZero("midrst");
        repeat (2) @(negedge gpuClk);
        expBgRead(18'h3FFFF, 32'h0F0F_0F0F);
        bgRequestAdr = 18'h3FFFF; bgRequest = 1'b1;
        i_nRst = 1'b1;
        runIdle("after_rst", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
